parking_gate_controller: RTL and testbench

- Upstream front-end of parking_management_system.
- Conditions raw gate hardware for one entry gate and one exit gate: loop sensors, pass sensors and badge readers.
- Runs one barrier state machine per gate.
- Emits the single-cycle car_entered / car_exited / is_uni_* event pulses that parking_management_system consumes.
- Entry is gated by that block's uni_is_vacated_space / is_vacated_space flags.

---
 rtl/parking_pkg.sv | 6 +
 rtl/parking_gate_controller_if.sv | 22 ++
 rtl/gate_fsm.sv | 55 +++++
 rtl/sensor_debouncer.sv | 29 ++
 rtl/parking_gate_controller.sv | 30 +++
 tb/tb_parking_gate_controller.sv | 214 +++++++++++++++++++++
 6 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared gate state type and default timing constants
package parking_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, OPEN, PASSING, CLEAR} gate_state_t;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int OPEN_TIMEOUT_DEF = 1000;
endpackage

// File: rtl/parking_gate_controller_if.sv
// parking_gate_if: raw gate hardware, space flags and event outputs of the gate controller
interface parking_gate_if;
  logic en_loop_raw, en_pass_raw, en_badge_valid, en_badge_uni;
  logic ex_loop_raw, ex_pass_raw, ex_badge_valid, ex_badge_uni;
  logic uni_is_vacated_space, is_vacated_space;
  logic en_barrier_open, ex_barrier_open, en_denied;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  modport master (
    output en_loop_raw, en_pass_raw, en_badge_valid, en_badge_uni,
    output ex_loop_raw, ex_pass_raw, ex_badge_valid, ex_badge_uni,
    output uni_is_vacated_space, is_vacated_space,
    input en_barrier_open, ex_barrier_open, en_denied,
    input car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
  );
  modport slave (
    input en_loop_raw, en_pass_raw, en_badge_valid, en_badge_uni,
    input ex_loop_raw, ex_pass_raw, ex_badge_valid, ex_badge_uni,
    input uni_is_vacated_space, is_vacated_space,
    output en_barrier_open, ex_barrier_open, en_denied,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
  );
endinterface

// File: rtl/gate_fsm.sv
// gate_fsm: barrier state machine for one gate, optional space check on badge
module gate_fsm import parking_pkg::*; #(
  parameter int OPEN_TIMEOUT = 1000,
  parameter int TMR_W = $clog2(OPEN_TIMEOUT + 1),
  parameter bit CHECK_SPACE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic loop,
  input  logic pass,
  input  logic badge_valid,
  input  logic badge_uni,
  input  logic uni_space,
  input  logic space,
  output logic barrier_open,
  output logic denied,
  output logic car_event,
  output logic car_uni
);
  gate_state_t state, next;
  logic [TMR_W-1:0] tmr;
  logic uni_q, granted;
  // next-state decode; a dropping loop in ARMED wins over a same-cycle badge
  always_comb begin
    next = state;
    granted = !CHECK_SPACE || (badge_uni ? uni_space : space);
    case (state)
      IDLE:    next = loop ? ARMED : IDLE;
      ARMED:   next = !loop ? IDLE : !badge_valid ? ARMED : granted ? OPEN : CLEAR;
      OPEN:    next = pass ? PASSING : tmr >= TMR_W'(OPEN_TIMEOUT - 1) ? CLEAR : OPEN;
      PASSING: next = pass ? PASSING : CLEAR;
      CLEAR:   next = loop ? CLEAR : IDLE;
      default: next = IDLE;
    endcase
  end
  // state, timeout counter, badge latch and registered outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      tmr <= '0;
      uni_q <= 1'b0;
      barrier_open <= 1'b0;
      denied <= 1'b0;
      car_event <= 1'b0;
      car_uni <= 1'b0;
    end else begin
      state <= next;
      tmr <= state != OPEN ? '0 : tmr == TMR_W'(OPEN_TIMEOUT) ? tmr : tmr + 1'b1;
      if (state == ARMED && badge_valid) uni_q <= badge_uni;
      barrier_open <= next == OPEN || next == PASSING;
      denied <= state == ARMED && next == CLEAR;
      car_event <= state == PASSING && next == CLEAR;
      car_uni <= state == PASSING && next == CLEAR && uni_q;
    end
endmodule

// File: rtl/sensor_debouncer.sv
// sensor_debouncer: 2-flop synchronizer followed by a consecutive-stable-cycles debouncer
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic s1, s2;
  logic [CW-1:0] cnt;
  // synchronize, then let db follow only after DEBOUNCE_CYCLES straight disagreeing samples
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: conditions entry/exit gate sensors and runs one barrier FSM per gate
module parking_gate_controller import parking_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int TMR_W = $clog2(OPEN_TIMEOUT + 1)
) (
  input logic clk,
  input logic reset,
  parking_gate_if.slave gate
);
  logic en_loop, en_pass, ex_loop, ex_pass, ex_denied_unused;
  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_loop (.clk, .reset, .raw(gate.en_loop_raw), .db(en_loop));
  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_pass (.clk, .reset, .raw(gate.en_pass_raw), .db(en_pass));
  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ex_loop (.clk, .reset, .raw(gate.ex_loop_raw), .db(ex_loop));
  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ex_pass (.clk, .reset, .raw(gate.ex_pass_raw), .db(ex_pass));
  gate_fsm #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .TMR_W(TMR_W), .CHECK_SPACE(1'b1)) u_en (
    .clk, .reset, .loop(en_loop), .pass(en_pass),
    .badge_valid(gate.en_badge_valid), .badge_uni(gate.en_badge_uni),
    .uni_space(gate.uni_is_vacated_space), .space(gate.is_vacated_space),
    .barrier_open(gate.en_barrier_open), .denied(gate.en_denied),
    .car_event(gate.car_entered), .car_uni(gate.is_uni_car_entered)
  );
  gate_fsm #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .TMR_W(TMR_W), .CHECK_SPACE(1'b0)) u_ex (
    .clk, .reset, .loop(ex_loop), .pass(ex_pass),
    .badge_valid(gate.ex_badge_valid), .badge_uni(gate.ex_badge_uni),
    .uni_space(gate.uni_is_vacated_space), .space(gate.is_vacated_space),
    .barrier_open(gate.ex_barrier_open), .denied(ex_denied_unused),
    .car_event(gate.car_exited), .car_uni(gate.is_uni_car_exited)
  );
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed and randomized checks of the two-gate controller
module tb_parking_gate_controller;
  localparam int DEB = 4;
  localparam int TO = 20;
  localparam int LAT = 2 + DEB;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  parking_gate_if gif();
  parking_gate_controller #(.DEBOUNCE_CYCLES(DEB), .OPEN_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .gate(gif));
  always #5 clk = ~clk;
  logic [6:0] outs;
  logic [3:0] raws, dbs;
  assign outs = {gif.en_barrier_open, gif.ex_barrier_open, gif.en_denied, gif.car_entered,
                 gif.is_uni_car_entered, gif.car_exited, gif.is_uni_car_exited};
  assign raws = {gif.ex_pass_raw, gif.ex_loop_raw, gif.en_pass_raw, gif.en_loop_raw};
  assign dbs = {dut.ex_pass, dut.ex_loop, dut.en_pass, dut.en_loop};
  // reference debouncer: value flips once the last DEB synchronized samples all disagree with it
  logic [DEB+1:0] hist [4];
  logic [3:0] mdb;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      mdb = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        hist[i] = {hist[i][DEB:0], raws[i]};
        if (hist[i][DEB+1:2] == {DEB{~mdb[i]}}) mdb[i] = ~mdb[i];
      end
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cnt, evt;
    logic ue, ux;
    {gif.en_loop_raw, gif.en_pass_raw, gif.en_badge_valid, gif.en_badge_uni} = '0;
    {gif.ex_loop_raw, gif.ex_pass_raw, gif.ex_badge_valid, gif.ex_badge_uni} = '0;
    {gif.uni_is_vacated_space, gif.is_vacated_space} = '0;
    step(3);
    chk("in_reset_outs", outs, 0);
    reset = 1'b1;
    evt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      evt |= (outs != 0) || (dbs != 0);
    end
    chk("idle_quiet_50", evt, 0);
    // university entry; space flag drops after grant and must not abort
    gif.en_loop_raw = 1'b1;
    step(LAT + 2);
    gif.en_badge_valid = 1'b1;
    gif.en_badge_uni = 1'b1;
    gif.uni_is_vacated_space = 1'b1;
    chk("uni_pre_badge_closed", gif.en_barrier_open, 0);
    step();
    gif.en_badge_valid = 1'b0;
    gif.uni_is_vacated_space = 1'b0;
    chk("uni_open_after_badge", gif.en_barrier_open, 1);
    gif.en_pass_raw = 1'b1;
    step(10);
    gif.en_pass_raw = 1'b0;
    step(LAT);
    chk("uni_no_early_event", {gif.car_entered, gif.en_barrier_open}, 2'b01);
    step();
    chk("uni_event", {gif.car_entered, gif.is_uni_car_entered, gif.en_barrier_open}, 3'b110);
    step();
    chk("uni_event_one_cycle", {gif.car_entered, gif.is_uni_car_entered}, 0);
    gif.en_loop_raw = 1'b0;
    step(LAT + 2);
    // non-university badge with only the university space free: denied
    gif.uni_is_vacated_space = 1'b1;
    gif.is_vacated_space = 1'b0;
    gif.en_loop_raw = 1'b1;
    step(LAT + 2);
    gif.en_badge_valid = 1'b1;
    gif.en_badge_uni = 1'b0;
    step();
    gif.en_badge_valid = 1'b0;
    chk("deny_pulse", {gif.en_denied, gif.en_barrier_open}, 2'b10);
    step();
    chk("deny_one_cycle", gif.en_denied, 0);
    evt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      evt |= gif.en_barrier_open | gif.car_entered | gif.en_denied;
    end
    chk("deny_no_open_no_event", evt, 0);
    gif.en_loop_raw = 1'b0;
    step(LAT + 2);
    // timeout with no pass
    gif.is_vacated_space = 1'b1;
    gif.en_loop_raw = 1'b1;
    step(LAT + 2);
    gif.en_badge_valid = 1'b1;
    gif.en_badge_uni = 1'($urandom_range(0, 1));
    step();
    gif.en_badge_valid = 1'b0;
    cnt = 0;
    evt = 0;
    for (int i = 0; i < 30; i++) begin
      cnt += int'(gif.en_barrier_open);
      evt |= gif.car_entered;
      step();
    end
    chk("timeout_open_cycles", cnt, TO);
    chk("timeout_no_event", evt, 0);
    gif.en_loop_raw = 1'b0;
    step(LAT + 2);
    // bouncing loop never arms, so a badge is ignored
    evt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) gif.en_loop_raw = ~gif.en_loop_raw;
      gif.en_badge_valid = (i == 20);
      step();
      evt |= gif.en_barrier_open | gif.en_denied | dut.en_loop;
    end
    gif.en_badge_valid = 1'b0;
    gif.en_loop_raw = 1'b0;
    chk("bounce_rejected", evt, 0);
    step(LAT + 2);
    // simultaneous entry and exit
    ue = 1'($urandom_range(0, 1));
    ux = 1'($urandom_range(0, 1));
    gif.en_loop_raw = 1'b1;
    gif.ex_loop_raw = 1'b1;
    step(LAT + 2);
    {gif.en_badge_valid, gif.en_badge_uni, gif.ex_badge_valid, gif.ex_badge_uni} = {1'b1, ue, 1'b1, ux};
    step();
    {gif.en_badge_valid, gif.ex_badge_valid} = '0;
    chk("sim_both_open", {gif.en_barrier_open, gif.ex_barrier_open}, 2'b11);
    gif.en_pass_raw = 1'b1;
    gif.ex_pass_raw = 1'b1;
    step($urandom_range(8, 14));
    gif.en_pass_raw = 1'b0;
    gif.ex_pass_raw = 1'b0;
    step(LAT);
    chk("sim_no_early", {gif.car_entered, gif.car_exited}, 0);
    step();
    chk("sim_events", {gif.car_entered, gif.is_uni_car_entered, gif.car_exited, gif.is_uni_car_exited},
        {1'b1, ue, 1'b1, ux});
    step();
    chk("sim_one_cycle", {gif.car_entered, gif.car_exited}, 0);
    gif.en_loop_raw = 1'b0;
    gif.ex_loop_raw = 1'b0;
    step(LAT + 2);
    // exit needs no space
    {gif.uni_is_vacated_space, gif.is_vacated_space} = '0;
    gif.ex_loop_raw = 1'b1;
    step(LAT + 2);
    gif.ex_badge_valid = 1'b1;
    gif.ex_badge_uni = 1'b0;
    step();
    gif.ex_badge_valid = 1'b0;
    chk("exit_ignores_space", gif.ex_barrier_open, 1);
    step(TO + 2);
    gif.ex_loop_raw = 1'b0;
    step(LAT + 2);
    // reset during PASSING
    {gif.uni_is_vacated_space, gif.is_vacated_space} = 2'b11;
    gif.en_loop_raw = 1'b1;
    step(LAT + 2);
    gif.en_badge_valid = 1'b1;
    gif.en_badge_uni = 1'b1;
    step();
    gif.en_badge_valid = 1'b0;
    gif.en_pass_raw = 1'b1;
    step(LAT + 2);
    chk("rst_passing_open", gif.en_barrier_open, 1);
    #2;
    reset = 1'b0;
    gif.en_pass_raw = 1'b0;
    gif.en_loop_raw = 1'b0;
    #1;
    chk("rst_async_drop", outs, 0);
    step(2);
    reset = 1'b1;
    evt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      evt |= outs != 0;
    end
    chk("rst_no_event", evt, 0);
    // random sensor noise without badges: debounced values follow the reference, outputs stay quiet
    evt = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) gif.en_loop_raw = ~gif.en_loop_raw;
      if ($urandom_range(0, 5) == 0) gif.en_pass_raw = ~gif.en_pass_raw;
      if ($urandom_range(0, 5) == 0) gif.ex_loop_raw = ~gif.ex_loop_raw;
      if ($urandom_range(0, 5) == 0) gif.ex_pass_raw = ~gif.ex_pass_raw;
      step();
      chk("rand_debounce", dbs, mdb);
      evt |= outs != 0;
    end
    chk("rand_quiet", evt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
